// File: rtl/typed_rr_arbiter_if.sv
// Request/grant and valid/ready bundle between N requesters, the arbiter and one consumer.
// Payload type and requester count are parameters and must match the arbiter's.
interface typed_rr_arbiter_if #(
    parameter int  N = 4,
    parameter type T = logic [7:0]
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    T              req_data [N];
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic          out_ready;
    T              out_data;
    logic [IW-1:0] out_idx;
    logic          busy;

    modport master (
        output req, req_data, out_ready,
        input  gnt, out_valid, out_data, out_idx, busy
    );

    modport slave (
        input  req, req_data, out_ready,
        output gnt, out_valid, out_data, out_idx, busy
    );
endinterface

// File: rtl/typed_rr_arbiter.sv
// Round-robin arbiter: captures one requester's payload, offers it on valid/ready,
// then optionally idles HOLD cycles before the next grant.
module typed_rr_arbiter #(
    parameter int  N    = 4,
    parameter type T    = logic [7:0],
    parameter int  HOLD = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    typed_rr_arbiter_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $bits(T);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_COOL = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_cnt;
    logic [N-1:0]  r_gnt;
    logic [DW-1:0] r_data;

    logic [IW-1:0] w_win;
    logic          w_found;
    logic          w_grant;
    logic          w_hs;
    logic [N-1:0]  w_gnt_next;
    logic [DW-1:0] w_win_data;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        logic [IW-1:0] j;
        w_found = 1'b0;
        w_win   = '0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(r_ptr) + k) % N);
            if (!w_found && bus.req[j]) begin
                w_found = 1'b1;
                w_win   = j;
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && w_found;
    assign w_hs       = (r_state == S_SEND) && bus.out_ready;
    assign w_win_data = bus.req_data[w_win];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_gnt
            assign w_gnt_next[gi] = w_grant && (w_win == IW'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_SEND;
            S_SEND:  if (bus.out_ready) w_state_next = (HOLD == 0) ? S_IDLE : S_COOL;
            S_COOL:  if (r_cnt == 8'd0) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_cnt   <= 8'd0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            if (w_grant) begin
                r_idx <= w_win;
            end
            if (w_hs) begin
                r_ptr <= (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
                if (HOLD != 0) begin
                    r_cnt <= 8'(HOLD - 1);
                end
            end else if (r_state == S_COOL && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Payload register spans the full width of T; only the IDLE grant loads it.
    generate
        if (DW > 0) begin : g_out_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (w_grant) begin
                    r_data <= w_win_data;
                end
            end
        end
    endgenerate

    assign bus.gnt       = r_gnt;
    assign bus.out_valid = (r_state == S_SEND);
    assign bus.out_data  = T'(r_data);
    assign bus.out_idx   = r_idx;
    assign bus.busy      = (r_state != S_IDLE);
endmodule
